// File: rtl/weight_update_unit.sv
// In-place SGD weight update over one layer's weight RAM:
// W[j][i] <= sat8(W[j][i] - sat8(lr * sat16(delta[j] * x[i]))), one weight every 3 cycles.
module weight_update_unit #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3,
  parameter int IW    = 2,
  parameter int OW    = 2,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    lr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] w_raddr,
  output logic          w_ren,
  input  logic [7:0]    w_rdata,
  output logic [AW-1:0] w_waddr,
  output logic          w_wen,
  output logic [7:0]    w_wdata,
  output logic [IW-1:0] x_idx,
  input  logic [7:0]    x_in,
  output logic [OW-1:0] d_idx,
  input  logic [15:0]   d_in
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [OW-1:0] j_q, j_d;
  logic [7:0]    lr_q, lr_d;
  logic [7:0]    w_wdata_q, w_wdata_d;
  logic [AW-1:0] addr;

  logic signed [23:0] d_ext, x_ext, prod_g;
  logic signed [15:0] grad;
  logic signed [23:0] g_ext, lr_ext, prod_s;
  logic signed [7:0]  step;
  logic signed [8:0]  diff;
  logic signed [7:0]  w_new;

  function automatic logic signed [15:0] sat16(input logic signed [23:0] v);
    if (v > 24'sd32767)       return 16'sh7FFF;
    else if (v < -24'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  function automatic logic signed [7:0] sat8_w24(input logic signed [23:0] v);
    if (v > 24'sd127)       return 8'sh7F;
    else if (v < -24'sd128) return 8'sh80;
    else                    return v[7:0];
  endfunction

  function automatic logic signed [7:0] sat8_w9(input logic signed [8:0] v);
    if (v > 9'sd127)       return 8'sh7F;
    else if (v < -9'sd128) return 8'sh80;
    else                   return v[7:0];
  endfunction

  // Datapath: operands are explicitly sign-extended to the product width so the
  // multiplies stay exact (|product| < 2^23 for all 16x8 operands).
  always_comb begin
    d_ext  = {{8{d_in[15]}}, d_in};
    x_ext  = {{16{x_in[7]}}, x_in};
    prod_g = d_ext * x_ext;
    grad   = sat16(prod_g >>> 5);
    g_ext  = {{8{grad[15]}}, grad};
    lr_ext = {{16{lr_q[7]}}, lr_q};
    prod_s = g_ext * lr_ext;
    step   = sat8_w24(prod_s >>> 13);
    diff   = {w_rdata[7], w_rdata} - {step[7], step};
    w_new  = sat8_w9(diff);
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    lr_d      = lr_q;
    w_wdata_d = w_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          lr_d    = lr;
          i_d     = '0;
          j_d     = '0;
          state_d = S_READ;
        end
      end
      S_READ:  state_d = S_WAIT;
      S_WAIT: begin
        w_wdata_d = w_new;
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        if (i_q == IW'(N_IN - 1) && j_q == OW'(N_OUT - 1)) begin
          state_d = S_DONE;
        end else begin
          if (i_q == IW'(N_IN - 1)) begin
            i_d = '0;
            j_d = j_q + OW'(1);
          end else begin
            i_d = i_q + IW'(1);
          end
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      lr_q      <= '0;
      w_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      lr_q      <= lr_d;
      w_wdata_q <= w_wdata_d;
    end
  end

  // i/j only move on the WRITE->READ transition, so the address and buffer
  // indices are stable from READ through WRITE of each weight.
  assign addr    = AW'(j_q) * AW'(N_IN) + AW'(i_q);
  assign w_raddr = addr;
  assign w_waddr = addr;
  assign x_idx   = i_q;
  assign d_idx   = j_q;
  assign w_wdata = w_wdata_q;
  assign w_ren   = (state_q == S_READ);
  assign w_wen   = (state_q == S_WRITE);
  assign busy    = (state_q == S_READ) || (state_q == S_WAIT) || (state_q == S_WRITE);
  assign done    = (state_q == S_DONE);

endmodule

// File: tb/tb_weight_update_unit.sv
// Scoreboard bench for weight_update_unit: behavioural weight RAM and x/delta buffers,
// expected writes queued by the stimulus and checked by an independent write monitor.
module tb_weight_update_unit;

  localparam int N_IN  = 4;
  localparam int N_OUT = 3;
  localparam int NW    = N_IN * N_OUT;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  lr;
  logic        busy;
  logic        done;
  logic [3:0]  w_raddr;
  logic        w_ren;
  logic [7:0]  w_rdata;
  logic [3:0]  w_waddr;
  logic        w_wen;
  logic [7:0]  w_wdata;
  logic [1:0]  x_idx;
  logic [7:0]  x_in;
  logic [1:0]  d_idx;
  logic [15:0] d_in;

  weight_update_unit #(.N_IN(N_IN), .N_OUT(N_OUT), .IW(2), .OW(2), .AW(4)) dut (
    .clk(clk), .reset(reset), .start(start), .lr(lr),
    .busy(busy), .done(done),
    .w_raddr(w_raddr), .w_ren(w_ren), .w_rdata(w_rdata),
    .w_waddr(w_waddr), .w_wen(w_wen), .w_wdata(w_wdata),
    .x_idx(x_idx), .x_in(x_in), .d_idx(d_idx), .d_in(d_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Weight RAM (1-cycle read latency) with a whole-array preload port for the stimulus.
  logic [7:0]  mem [16];
  logic        pl_en;
  logic [7:0]  pl_val;
  logic [7:0]  xv [4];
  logic [15:0] dv [3];

  always @(posedge clk) begin
    if (pl_en) begin
      for (int a = 0; a < 16; a++) mem[a] <= pl_val;
    end else if (w_wen) begin
      mem[w_waddr] <= w_wdata;
    end
    if (w_ren) w_rdata <= mem[w_raddr];
  end

  assign x_in = xv[x_idx];
  assign d_in = dv[d_idx];

  typedef struct {
    logic [3:0] addr;
    logic [1:0] i;
    logic [1:0] j;
    logic [7:0] data;
  } exp_t;

  exp_t       sbq[$];
  logic [7:0] exp_w [NW];
  int         n_vec = 0;
  int         n_err = 0;
  int         wr_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, want);
    end
  endtask

  // Write monitor: every DUT write is popped against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (w_wen) begin
        wr_cnt++;
        chk("ren_wen_overlap", {31'd0, w_ren}, 32'd0);
        if (sbq.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", w_waddr, w_wdata);
        end else begin
          e = sbq.pop_front();
          chk("wr_addr", {28'd0, w_waddr}, {28'd0, e.addr});
          chk("wr_idx", {28'd0, d_idx, x_idx}, {28'd0, e.j, e.i});
          chk($sformatf("wr_data[%0d]", e.addr), {24'd0, w_wdata}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic fill(input logic [7:0] v);
    @(negedge clk);
    pl_val = v;
    pl_en  = 1'b1;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic set_bufs(input logic [7:0] xval, input logic [15:0] dval);
    for (int i = 0; i < 4; i++) xv[i] = xval;
    for (int j = 0; j < 3; j++) dv[j] = dval;
  endtask

  task automatic push_exp();
    exp_t e;
    for (int a = 0; a < NW; a++) begin
      e.addr = 4'(a);
      e.i    = 2'(a % N_IN);
      e.j    = 2'(a / N_IN);
      e.data = exp_w[a];
      sbq.push_back(e);
    end
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < NW; a++)
      chk($sformatf("%s_mem[%0d]", tag, a), {24'd0, mem[a]}, {24'd0, exp_w[a]});
  endtask

  // Start sampled at edge k (start cycle k); done must be high in cycle k+37,
  // i.e. visible right after edge k+36.
  task automatic run_pass(input string tag, input logic [7:0] lrv, input bit mid_start);
    int cyc;
    push_exp();
    @(negedge clk);
    start = 1'b1;
    lr    = lrv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lr    = 8'h00;
    chk({tag, "_busy_after_start"}, {31'd0, busy}, 32'd1);
    cyc = 0;
    while (!done && cyc < 100) begin
      if (mid_start && cyc == 10) start = 1'b1;
      if (mid_start && cyc == 12) start = 1'b0;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, "_done_latency"}, cyc, 3 * NW);
    chk({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    chk({tag, "_writes_left"}, sbq.size(), 0);
    @(negedge clk);
    chk({tag, "_done_width"}, {31'd0, done}, 32'd0);
    sbq.delete();
  endtask

  initial begin
    int base;
    int guard;
    bit done_seen;
    reset = 1'b1;
    start = 1'b0;
    lr    = 8'h00;
    pl_en = 1'b0;
    pl_val = 8'h00;
    set_bufs(8'h00, 16'h0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_ren", {31'd0, w_ren}, 32'd0);
    chk("rst_wen", {31'd0, w_wen}, 32'd0);
    chk("rst_raddr", {28'd0, w_raddr}, 32'd0);
    chk("rst_wdata", {24'd0, w_wdata}, 32'd0);
    chk("rst_idx", {28'd0, d_idx, x_idx}, 32'd0);
    reset = 1'b0;

    // Nominal: g=0x2000, step=0x10, 0x20-0x10=0x10; second start mid-pass ignored.
    fill(8'h20);
    set_bufs(8'h20, 16'h2000);
    for (int a = 0; a < NW; a++) exp_w[a] = 8'h10;
    run_pass("nominal", 8'h10, 1'b1);
    check_mem("nominal");

    // Underflow: -128 - 16 saturates to 0x80.
    fill(8'h80);
    for (int a = 0; a < NW; a++) exp_w[a] = 8'h80;
    run_pass("underflow", 8'h10, 1'b0);

    // Overflow: delta negative gives step=0xF0, 127 + 16 saturates to 0x7F.
    fill(8'h7F);
    set_bufs(8'h20, 16'hE000);
    for (int a = 0; a < NW; a++) exp_w[a] = 8'h7F;
    run_pass("overflow", 8'h10, 1'b0);

    // Gradient and step saturation: g=0x7FFF, step=0x7F, 0 - 127 = 0x81.
    fill(8'h00);
    set_bufs(8'h7F, 16'h7FFF);
    for (int a = 0; a < NW; a++) exp_w[a] = 8'h81;
    run_pass("gradsat", 8'h20, 1'b0);

    // Reset after the 5th write has landed.
    fill(8'h20);
    set_bufs(8'h20, 16'h2000);
    for (int a = 0; a < NW; a++) exp_w[a] = 8'h10;
    push_exp();
    base = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    lr    = 8'h10;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    #1;
    while (wr_cnt < base + 5 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    chk("rst_mid_reach_5th_write", wr_cnt - base, 5);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_ren", {31'd0, w_ren}, 32'd0);
    chk("rst_mid_wen", {31'd0, w_wen}, 32'd0);
    chk("rst_mid_idx", {28'd0, d_idx, x_idx}, 32'd0);
    reset = 1'b0;
    chk("rst_mid_pending", sbq.size(), NW - 5);
    sbq.delete();
    done_seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    chk("rst_mid_no_done", {31'd0, done_seen}, 32'd0);
    chk("rst_mid_busy_idle", {31'd0, busy}, 32'd0);
    for (int a = 0; a < NW; a++) exp_w[a] = (a < 5) ? 8'h10 : 8'h20;
    check_mem("rst_mid");

    // Clean pass afterwards on the partially updated array.
    for (int a = 0; a < NW; a++) exp_w[a] = (a < 5) ? 8'h00 : 8'h10;
    run_pass("post_rst", 8'h10, 1'b0);
    check_mem("post_rst");

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
